// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-TX state encoding, clock default and line timing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    localparam int PS2_SYSTEM_CLOCK = 25_000_000;
    localparam int PS2_INHIBIT_US   = 100;   // clock held low before request-to-send
    localparam int PS2_TIMEOUT_US   = 2000;  // clock release to frame completion

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQUEST,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_t;

    // Convert a duration in microseconds into clk cycles.
    function automatic int ps2_cycles(input int clk_hz, input int us);
        return (clk_hz / 1_000_000) * us;
    endfunction

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command byte handshake and frame status between the system and the PS/2 transmitter.
// Latency: n/a (wires only).
// Backpressure: tx_valid is honoured only while tx_ready is high.
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, error
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, error
    );

endinterface

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for one PS/2 line, with a falling-edge strobe.
// Latency: level follows the pin after 2 cycles; fall is combinational from the flops.
// Backpressure: none.
module ps2_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Idle PS/2 lines are high, so reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= async_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter using the inhibit / request-to-send sequence.
// Latency: accept to clock pull-down 1 cycle; data line update 3 cycles after the device clock falls.
// Backpressure: tx_ready only in IDLE; tx_valid is ignored for the whole frame.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int SYSTEM_CLOCK   = PS2_SYSTEM_CLOCK,
    parameter int INHIBIT_CYCLES = ps2_cycles(SYSTEM_CLOCK, PS2_INHIBIT_US),
    parameter int TIMEOUT_CYCLES = ps2_cycles(SYSTEM_CLOCK, PS2_TIMEOUT_US)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe,
    ps2_host_tx_if.slave bus
);

    ps2_tx_state_t state, state_n;
    logic [15:0]   cnt, cnt_n;           // inhibit length, then frame timeout
    logic [3:0]    bit_idx, bit_idx_n;
    logic [8:0]    frame, frame_n;       // {parity, data}
    logic [9:0]    frame_bits;           // {stop, parity, data}, sent LSB first

    logic clk_oe_q, clk_oe_n;
    logic data_oe_q, data_oe_n;
    logic done_q, done_n;
    logic error_q, error_n;
    logic busy_q, busy_n;
    logic tx_ready_q, tx_ready_n;

    logic clk_s, clk_fall;
    logic data_s, data_fall;
    logic unused_data_fall;

    ps2_sync u_sync_clk (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ps2_clk_in),
        .level    (clk_s),
        .fall     (clk_fall)
    );

    ps2_sync u_sync_data (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ps2_data_in),
        .level    (data_s),
        .fall     (data_fall)
    );

    assign unused_data_fall = data_fall;
    assign frame_bits       = {1'b1, frame};

    // State, counters and all outputs are registered from their next values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            frame      <= '0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            frame      <= frame_n;
            clk_oe_q   <= clk_oe_n;
            data_oe_q  <= data_oe_n;
            done_q     <= done_n;
            error_q    <= error_n;
            busy_q     <= busy_n;
            tx_ready_q <= tx_ready_n;
        end
    end

    // Next-state and next-output decode for the request-to-send frame.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        frame_n   = frame;
        data_oe_n = data_oe_q;
        done_n    = 1'b0;
        error_n   = 1'b0;

        case (state)
            ST_IDLE: begin
                data_oe_n = 1'b0;
                if (bus.tx_valid && tx_ready_q) begin
                    frame_n = {odd_parity(bus.tx_data), bus.tx_data};
                    cnt_n   = '0;
                    state_n = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                data_oe_n = 1'b0;
                if (cnt == 16'(INHIBIT_CYCLES - 1)) begin
                    cnt_n     = '0;
                    data_oe_n = 1'b1;        // start bit, held until the first device clock
                    state_n   = ST_REQUEST;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end

            ST_REQUEST: begin
                cnt_n     = '0;
                bit_idx_n = '0;
                state_n   = ST_SEND;
            end

            ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
                // A stuck device must never wedge the link; timeout beats any edge.
                if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    error_n   = 1'b1;
                    data_oe_n = 1'b0;
                    state_n   = ST_IDLE;
                end else begin
                    cnt_n = cnt + 16'd1;
                    if (state == ST_SEND) begin
                        if (clk_fall) begin
                            data_oe_n = ~frame_bits[bit_idx];
                            bit_idx_n = bit_idx + 4'd1;
                            if (bit_idx == 4'd9) begin
                                state_n = ST_ACK;
                            end
                        end
                    end else if (state == ST_ACK) begin
                        data_oe_n = 1'b0;
                        if (clk_fall) begin
                            if (!data_s) begin
                                state_n = ST_WAIT_IDLE;
                            end else begin
                                error_n = 1'b1;
                                state_n = ST_IDLE;
                            end
                        end
                    end else begin
                        if (clk_s && data_s) begin
                            done_n  = 1'b1;
                            state_n = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                data_oe_n = 1'b0;
                state_n   = ST_IDLE;
            end
        endcase

        clk_oe_n   = (state_n == ST_INHIBIT) || (state_n == ST_REQUEST);
        busy_n     = (state_n != ST_IDLE);
        // Hold off acceptance during the done/error cycle so status is seen first.
        tx_ready_n = (state_n == ST_IDLE) && !done_n && !error_n;
    end

    assign ps2_clk_oe   = clk_oe_q;
    assign ps2_data_oe  = data_oe_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model plus a behavioural PS/2 device.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_host_tx;

    localparam int INH = 2500;
    localparam int TMO = 3000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic clk_oe, data_oe;
    logic ps2_clk_line, ps2_data_line;

    // Wired-AND open-drain lines: host or device may pull low.
    assign ps2_clk_line  = ~clk_oe  & ~dev_clk_low;
    assign ps2_data_line = ~data_oe & ~dev_data_low;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .SYSTEM_CLOCK   (25_000_000),
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (clk_oe),
        .ps2_data_oe (data_oe),
        .bus         (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Observer state
    int   cyc = 0, done_cnt = 0, err_cnt = 0;
    int   run = 0, req_pos = 0, last_run = 0, last_req = 0;
    int   rel_cyc = 0, err_cyc = 0;
    logic prev_clk_oe = 1'b0;
    int   hp = 20;   // device clock half period in cycles

    // Observe outputs 1 time unit after every rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (bus.done === 1'b1) done_cnt++;
        if (bus.error === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (clk_oe === 1'b1) begin
            run++;
            if (data_oe === 1'b1 && req_pos == 0) req_pos = run;
        end else if (prev_clk_oe === 1'b1) begin
            last_run = run;
            last_req = req_pos;
            run      = 0;
            req_pos  = 0;
            rel_cyc  = cyc;
        end
        prev_clk_oe = clk_oe;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 95000 cycles, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Expected line bits: data LSB first, odd parity, stop = 1.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic p;
        p = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, p, b};
    endfunction

    // Behavioural keyboard: waits for request-to-send, clocks the frame, optionally ACKs.
    task automatic dev_frame(input bit do_ack, input int abort_after, output logic [9:0] got);
        int waited;
        waited = 0;
        got    = '0;
        while (!(clk_oe == 1'b0 && ps2_data_line == 1'b0) && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        chk("request_seen", 32'(waited < 20000), 32'd1);
        if (waited >= 20000) return;
        repeat (hp) @(negedge clk);
        for (int e = 1; e <= 11; e++) begin
            if (e > abort_after) return;
            if (e == 11 && do_ack) begin
                dev_data_low = 1'b1;
                repeat (5) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (hp) @(negedge clk);
            if (e <= 10) got[e-1] = ps2_data_line;
            dev_clk_low = 1'b0;
            repeat (hp) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic start_byte(input logic [7:0] b);
        @(negedge clk);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_back", 32'(bus.tx_ready), 32'd1);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         exp_par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t       vecs [5];
    logic [9:0] got, got2;
    int         d0, e0, n, rdy;
    logic [7:0] rb;
    bit         rack;

    initial begin
        vecs[0] = '{8'hF4, 1'b1, 1'b0, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1, 0};
        vecs[2] = '{8'hA5, 1'b0, 1'b1, 0, 1};
        vecs[3] = '{8'h07, 1'b1, 1'b0, 1, 0};
        vecs[4] = '{8'h3C, 1'b1, 1'b1, 1, 0};

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", 32'(clk_oe), 32'd0);
        chk("rst_data_oe", 32'(data_oe), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        chk("rst_ready", 32'(bus.tx_ready), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_rst", 32'(bus.tx_ready), 32'd1);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            start_byte(vecs[i].data);
            dev_frame(vecs[i].ack, 11, got);
            wait_ready();
            repeat (5) @(negedge clk);
            chk("vec_data", 32'(got[7:0]), 32'(vecs[i].data));
            chk("vec_parity", 32'(got[8]), 32'(vecs[i].exp_par));
            chk("vec_stop", 32'(got[9]), 32'd1);
            chk("vec_done", 32'(done_cnt - d0), 32'(vecs[i].exp_done));
            chk("vec_error", 32'(err_cnt - e0), 32'(vecs[i].exp_err));
            chk("inhibit_len", 32'(last_run), 32'(INH + 1));
            chk("start_pos", 32'(last_req), 32'(INH + 1));
        end

        // Back-to-back 0xED then 0x02 with tx_valid held
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        bus.tx_data  = 8'hED;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_data  = 8'h02;
        dev_frame(1'b1, 11, got);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        rdy = 0;
        n   = 0;
        while (bus.busy !== 1'b1 && n < 200) begin
            if (bus.tx_ready === 1'b1) rdy++;
            @(negedge clk);
            n++;
        end
        bus.tx_valid = 1'b0;
        chk("b2b_ready_cycles", 32'(rdy), 32'd1);
        dev_frame(1'b1, 11, got2);
        wait_ready();
        repeat (5) @(negedge clk);
        chk("b2b_frame1", 32'(got), 32'(model_frame(8'hED)));
        chk("b2b_parity1", 32'(got[8]), 32'd1);
        chk("b2b_frame2", 32'(got2), 32'(model_frame(8'h02)));
        chk("b2b_parity2", 32'(got2[8]), 32'd0);
        chk("b2b_done", 32'(done_cnt - d0), 32'd2);
        chk("b2b_error", 32'(err_cnt - e0), 32'd0);

        // Device never clocks: timeout
        d0 = done_cnt;
        e0 = err_cnt;
        start_byte(8'h5A);
        n = 0;
        while (err_cnt == e0 && n < INH + TMO + 500) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_seen", 32'(err_cnt - e0), 32'd1);
        chk("timeout_cycles", 32'(err_cyc - rel_cyc), 32'(TMO));
        chk("timeout_clk_oe", 32'(clk_oe), 32'd0);
        chk("timeout_data_oe", 32'(data_oe), 32'd0);
        @(negedge clk);
        chk("timeout_ready", 32'(bus.tx_ready), 32'd1);
        chk("timeout_no_done", 32'(done_cnt - d0), 32'd0);

        // Reset in the middle of bit 4 of 0xFF
        d0 = done_cnt;
        e0 = err_cnt;
        start_byte(8'hFF);
        dev_frame(1'b1, 5, got);
        chk("busy_before_rst", 32'(bus.busy), 32'd1);
        chk("bits_before_rst", 32'(got[4:0]), 32'h1F);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_clk_oe", 32'(clk_oe), 32'd0);
        chk("arst_data_oe", 32'(data_oe), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_ready", 32'(bus.tx_ready), 32'd1);
        chk("arst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        d0 = done_cnt;
        start_byte(8'h00);
        dev_frame(1'b1, 11, got);
        wait_ready();
        repeat (5) @(negedge clk);
        chk("post_rst_frame", 32'(got), 32'(model_frame(8'h00)));
        chk("post_rst_parity", 32'(got[8]), 32'd1);
        chk("post_rst_done", 32'(done_cnt - d0), 32'd1);

        // tx_valid pulse with 0x55 during an active frame is ignored
        d0 = done_cnt;
        e0 = err_cnt;
        start_byte(8'hA3);
        fork
            dev_frame(1'b1, 11, got);
            begin
                repeat (INH + 200) @(negedge clk);
                bus.tx_data  = 8'h55;
                bus.tx_valid = 1'b1;
                @(negedge clk);
                bus.tx_valid = 1'b0;
            end
        join
        wait_ready();
        repeat (50) @(negedge clk);
        chk("ignore_frame", 32'(got), 32'(model_frame(8'hA3)));
        chk("ignore_idle", 32'(bus.busy), 32'd0);
        chk("ignore_done", 32'(done_cnt - d0), 32'd1);
        chk("ignore_error", 32'(err_cnt - e0), 32'd0);

        // Randomized frames against the reference model
        for (int r = 0; r < 6; r++) begin
            rb   = 8'($urandom_range(0, 255));
            rack = ($urandom_range(0, 3) != 0);
            hp   = $urandom_range(8, 40);
            d0   = done_cnt;
            e0   = err_cnt;
            start_byte(rb);
            dev_frame(rack, 11, got);
            wait_ready();
            repeat (5) @(negedge clk);
            chk("rand_frame", 32'(got), 32'(model_frame(rb)));
            chk("rand_done", 32'(done_cnt - d0), 32'(rack ? 1 : 0));
            chk("rand_error", 32'(err_cnt - e0), 32'(rack ? 0 : 1));
        end
        hp = 20;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the system to the keyboard using the PS/2 request-to-send sequence. It drives the shared open-drain PS/2 clock and data lines. It sits beside the PS/2 receive decoder in the keyboard front end. `busy` tells the top level to ignore decoder output while a command frame is in flight.

## Interface
- `SYSTEM_CLOCK`, default 25_000_000: clk frequency in Hz.
- `INHIBIT_CYCLES`, default 2500: cycles the clock line is held low before the request (100 us at 25 MHz).
- `TIMEOUT_CYCLES`, default 50000: maximum cycles from clock release to frame completion (2 ms).
- `clk`, input, 1: system clock. One clock domain.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `ps2_clk_in`, input, 1: PS/2 clock line level (asynchronous).
- `ps2_data_in`, input, 1: PS/2 data line level (asynchronous).
- `ps2_clk_oe`, output, 1: 1 pulls the PS/2 clock line low; 0 releases it.
- `ps2_data_oe`, output, 1: 1 pulls the PS/2 data line low; 0 releases it.
- `tx_data`, input, 8: byte to send.
- `tx_valid`, input, 1: send request.
- `tx_ready`, output, 1: 1 only in IDLE.
- `busy`, output, 1: 1 in every state except IDLE.
- `done`, output, 1: one-cycle pulse when the device acknowledged and both lines returned high.
- `error`, output, 1: one-cycle pulse on timeout or missing ACK.

## Operation
- Input sync: each PS/2 input passes through a 2-flop synchronizer.
- Falling-edge detect: `fall` = previous synced clock 1 and current synced clock 0.
- Handshake: a byte is accepted when `tx_valid && tx_ready`. `tx_data` is latched, and the odd parity bit is computed as ~^tx_data. `tx_valid` is ignored while busy.
- State machine:
  - IDLE: both outputs 0. On accept, go to INHIBIT and clear the counter.
  - INHIBIT: `ps2_clk_oe`=1, `ps2_data_oe`=0 for INHIBIT_CYCLES cycles, then go to REQUEST.
  - REQUEST: `ps2_clk_oe`=1, `ps2_data_oe`=1 (start bit) for exactly 1 cycle. Then go to SEND with bit index 0 and clear the timeout counter.
  - SEND: `ps2_clk_oe`=0. On each `fall`, drive the next bit with `ps2_data_oe` = ~bit:
    - index 0-7: data bits, LSB first;
    - index 8: parity;
    - index 9: stop bit (release).
    - After the stop bit is driven, go to ACK.
  - ACK: lines released. On the next `fall`, sample synced data: 0 goes to WAIT_IDLE, 1 pulses `error` and returns to IDLE.
  - WAIT_IDLE: when synced clock and data are both 1, pulse `done` and go to IDLE.
- Timeout: a 16-bit counter runs in SEND, ACK and WAIT_IDLE. On reaching TIMEOUT_CYCLES, pulse `error`, release both lines and go to IDLE. It has priority over a same-cycle `fall`.
- `done` and `error` are mutually exclusive; exactly one pulses per accepted byte.
- Reset: asynchronous. All outputs go to 0 immediately (lines released, `tx_ready`=1 after reset deasserts), state returns to IDLE and the frame is discarded.

## Timing
- Accept to `ps2_clk_oe` rising: 1 cycle.
- `ps2_clk_oe` high for INHIBIT_CYCLES+1 cycles; `ps2_data_oe` rises in the last of them.
- Data line update: 3 cycles after the physical clock falls (2 sync flops plus the registered output). This is well inside the 30-50 us clock-low phase.
- `done`/`error` are registered one-cycle pulses. `tx_ready` returns to 1 the cycle after the pulse.
- Back-to-back transfers: `tx_valid` held high starts the next frame the cycle `tx_ready` returns.

## Structure
- Shared package `ps2_pkg`: state enum, `SYSTEM_CLOCK` default, PS/2 timing constants (inhibit, timeout). The decoder uses the same constants.
- One natural sub-module: `ps2_sync`, a 2-flop synchronizer with falling-edge output. The receiver should also adopt it.
- Counters: a single 16-bit counter shared by INHIBIT and the timeout, plus a 4-bit bit index.

## Test plan
- Send 0xF4 with a device model clocking at 10 kHz and ACKing:
  - `ps2_clk_oe` high for 2501 cycles;
  - data line bits after the start bit are 0,0,1,0,1,1,1,1, parity 0, stop 1;
  - `done` pulses once and `error` never pulses.
- Send 0xED, then 0x02, back-to-back with `tx_valid` held: two complete frames. Parity is 1 for 0xED and 0 for 0x02, and `done` pulses twice.
- Device model never clocks after the request: `error` pulses exactly TIMEOUT_CYCLES cycles after clock release, both `*_oe` are 0 and `tx_ready`=1.
- Device omits the ACK (data stays high on the 11th falling edge): `error` pulses and `done` does not.
- Assert `rst_n`=0 during bit 4 of 0xFF: `ps2_clk_oe`/`ps2_data_oe` go to 0 with no clk edge. After release, `tx_ready`=1 and the next 0x00 frame (parity 1) completes normally.
- Pulse `tx_valid` with 0x55 during an active frame: ignored. Only the original byte is transmitted.
